hdlc_tx: RTL



---
 rtl/hdlc_pkg.sv | 15 +
 rtl/hdlc_tx_if.sv | 12 +
 rtl/hdlc_bit_clk_gen.sv | 35 +++
 rtl/hdlc_tx.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/hdlc_pkg.sv
// Shared constants and FSM encoding for the HDLC transmit path.
package hdlc_pkg;

  localparam logic [7:0] FLAG      = 8'h7E;
  localparam int         STUFF_RUN = 5;

  typedef enum logic [2:0] {
    IDLE,
    OPEN,
    DATA,
    CLOSE,
    GAP
  } state_t;

endpackage

// File: rtl/hdlc_tx_if.sv
// Byte-stream handshake between the DMA/FIFO side and the HDLC transmitter.
interface hdlc_tx_if;

  logic       tvalid;
  logic       tready;
  logic [7:0] tdata;
  logic       tlast;

  modport master (output tvalid, output tdata, output tlast, input tready);
  modport slave  (input tvalid, input tdata, input tlast, output tready);

endinterface

// File: rtl/hdlc_bit_clk_gen.sv
// Bit-period timing: low phase then high phase, HALF_DIV clk cycles each.
module hdlc_bit_clk_gen #(
  parameter int HALF_DIV = 2
) (
  input  logic clk,
  input  logic rstn,
  input  logic en,
  output logic bit_start,
  output logic bit_end,
  output logic clk_out
);

  localparam int PERIOD = 2 * HALF_DIV;
  localparam int CW     = $clog2(PERIOD);

  logic [CW-1:0] cnt;

  // clk_out is registered so it lines up with the registered data_out in the top.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt     <= '0;
      clk_out <= 1'b0;
    end else begin
      clk_out <= en && (cnt >= CW'(HALF_DIV));
      if (!en || cnt == CW'(PERIOD - 1))
        cnt <= '0;
      else
        cnt <= cnt + CW'(1);
    end
  end

  assign bit_start = en && (cnt == '0);
  assign bit_end   = en && (cnt == CW'(PERIOD - 1));

endmodule

// File: rtl/hdlc_tx.sv
// HDLC transmitter: opening flags, bit-stuffed MSB-first payload, closing flag, idle gap.
module hdlc_tx
  import hdlc_pkg::*;
#(
  parameter int HALF_DIV   = 2,
  parameter int OPEN_FLAGS = 4,
  parameter int GAP_CYCLES = 256
) (
  input  logic       clk,
  input  logic       rstn,
  hdlc_tx_if.slave   s,
  output logic       clk_out,
  output logic       data_out,
  output logic       busy,
  output logic       done,
  output logic       underrun
);

  localparam int FLAG_W = (OPEN_FLAGS > 1) ? $clog2(OPEN_FLAGS) : 1;
  localparam int GAP_W  = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  state_t            state, state_nxt;
  logic [7:0]        shifter, shifter_nxt;
  logic              cur_last, cur_last_nxt;
  logic [3:0]        bit_cnt, bit_cnt_nxt;
  logic [2:0]        ones_cnt, ones_nxt;
  logic [FLAG_W-1:0] flag_cnt, flag_nxt;
  logic [GAP_W-1:0]  gap_cnt, gap_nxt;
  logic              hold_valid, hold_last;
  logic [7:0]        hold_data;
  logic              load, done_nxt, underrun_nxt, cur_bit, stuff_now, byte_done;
  logic              bit_en, bit_start, bit_end;

  assign bit_en    = (state == OPEN) || (state == DATA) || (state == CLOSE);
  assign stuff_now = (ones_cnt == 3'(STUFF_RUN));
  assign busy      = (state != IDLE);
  assign s.tready  = !hold_valid && ((state == OPEN) || (state == DATA));

  hdlc_bit_clk_gen #(.HALF_DIV(HALF_DIV)) u_bit_clk (
    .clk       (clk),
    .rstn      (rstn),
    .en        (bit_en),
    .bit_start (bit_start),
    .bit_end   (bit_end),
    .clk_out   (clk_out)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state    <= IDLE;
      shifter  <= '0;
      cur_last <= 1'b0;
      bit_cnt  <= '0;
      ones_cnt <= '0;
      flag_cnt <= '0;
      gap_cnt  <= '0;
      done     <= 1'b0;
      underrun <= 1'b0;
    end else begin
      state    <= state_nxt;
      shifter  <= shifter_nxt;
      cur_last <= cur_last_nxt;
      bit_cnt  <= bit_cnt_nxt;
      ones_cnt <= ones_nxt;
      flag_cnt <= flag_nxt;
      gap_cnt  <= gap_nxt;
      done     <= done_nxt;
      underrun <= underrun_nxt;
    end
  end

  // A byte parked here after the frame's last byte is kept for the next frame.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      hold_valid <= 1'b0;
      hold_data  <= '0;
      hold_last  <= 1'b0;
    end else if (s.tvalid && s.tready) begin
      hold_valid <= 1'b1;
      hold_data  <= s.tdata;
      hold_last  <= s.tlast;
    end else if (load) begin
      hold_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)
      data_out <= 1'b1;
    else if (!bit_en)
      data_out <= 1'b1;
    else if (bit_start)
      data_out <= cur_bit;
  end

  always_comb begin
    state_nxt    = state;
    shifter_nxt  = shifter;
    cur_last_nxt = cur_last;
    bit_cnt_nxt  = bit_cnt;
    ones_nxt     = ones_cnt;
    flag_nxt     = flag_cnt;
    gap_nxt      = gap_cnt;
    load         = 1'b0;
    done_nxt     = 1'b0;
    underrun_nxt = 1'b0;
    cur_bit      = 1'b1;
    byte_done    = 1'b0;

    unique case (state)
      IDLE: begin
        if (s.tvalid || hold_valid) begin
          state_nxt   = OPEN;
          bit_cnt_nxt = '0;
          flag_nxt    = '0;
        end
      end

      OPEN: begin
        cur_bit = FLAG[3'd7 - bit_cnt[2:0]];
        if (bit_end) begin
          if (bit_cnt == 4'd7) begin
            bit_cnt_nxt = '0;
            if (flag_cnt == FLAG_W'(OPEN_FLAGS - 1)) begin
              flag_nxt = '0;
              if (hold_valid) begin
                load      = 1'b1;
                ones_nxt  = '0;
                state_nxt = DATA;
              end else begin
                underrun_nxt = 1'b1;
                state_nxt    = CLOSE;
              end
            end else begin
              flag_nxt = flag_cnt + FLAG_W'(1);
            end
          end else begin
            bit_cnt_nxt = bit_cnt + 4'd1;
          end
        end
      end

      // A run of ones reaching STUFF_RUN on a byte's final bit keeps the byte open for the stuff bit.
      DATA: begin
        cur_bit = stuff_now ? 1'b0 : shifter[7];
        if (bit_end) begin
          if (stuff_now) begin
            ones_nxt  = '0;
            byte_done = (bit_cnt == 4'd8);
          end else begin
            shifter_nxt = {shifter[6:0], 1'b0};
            bit_cnt_nxt = bit_cnt + 4'd1;
            ones_nxt    = shifter[7] ? ones_cnt + 3'd1 : 3'd0;
            byte_done   = (bit_cnt == 4'd7) &&
                          !(shifter[7] && (ones_cnt == 3'(STUFF_RUN - 1)));
          end
          if (byte_done) begin
            bit_cnt_nxt = '0;
            if (cur_last) begin
              state_nxt = CLOSE;
            end else if (hold_valid) begin
              load = 1'b1;
            end else begin
              underrun_nxt = 1'b1;
              state_nxt    = CLOSE;
            end
          end
        end
      end

      CLOSE: begin
        cur_bit = FLAG[3'd7 - bit_cnt[2:0]];
        if (bit_end) begin
          if (bit_cnt == 4'd7) begin
            bit_cnt_nxt = '0;
            done_nxt    = 1'b1;
            gap_nxt     = '0;
            state_nxt   = GAP;
          end else begin
            bit_cnt_nxt = bit_cnt + 4'd1;
          end
        end
      end

      GAP: begin
        if (gap_cnt == GAP_W'(GAP_CYCLES - 1)) begin
          gap_nxt   = '0;
          state_nxt = IDLE;
        end else begin
          gap_nxt = gap_cnt + GAP_W'(1);
        end
      end

      default: state_nxt = IDLE;
    endcase

    if (load) begin
      shifter_nxt  = hold_data;
      cur_last_nxt = hold_last;
    end
  end

endmodule
